turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Two-player turn controller for the aim datapath (`pos_aim`). It grants the shared `pos_aim` button inputs to one player at a time. On that player's fire press it latches the aim vector (`x_pos`, `run`, `rise`, `dir`), flies a projectile across the 32×32 field with Bresenham stepping, and scores the result. It then hands the turn to the other player. It sits between the player button synchronisers and `pos_aim`, and feeds the display and score logic.

## Interface
- `STEP_DIV`, default 4: clock cycles per projectile step (≥1).
- `TOP_Y`, default 31: y row that ends a flight.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `p0_btn` in 5: player 0 buttons, `[0]` left_x, `[1]` right_x, `[2]` left_aim, `[3]` right_aim, `[4]` fire. Already synchronised.
- `p1_btn` in 5: player 1 buttons, same bit map.
- `x_pos`, `run`, `rise` in 5 each: from `pos_aim`.
- `dir` in 1: from `pos_aim`; 1 = +x, 0 = −x.
- `target_x` in 5: target column on row `TOP_Y`.
- `left_x`, `right_x`, `left_aim`, `right_aim` out 1 each: to `pos_aim`.
- `turn` out 1: active player.
- `shot_active` out 1: high while in FLY.
- `shot_x`, `shot_y` out 5 each: projectile position.
- `hit`, `miss` out 1 each: one-cycle result pulses.
- `score0`, `score1` out 4 each: saturating scores.

## Operation
- States: AIM, FLY, RESULT. Reset enters AIM.
- Reset values: `turn`=0, scores 0, `shot_x`/`shot_y` 0, `shot_active`/`hit`/`miss` 0, fire-edge history 0.
- AIM:
  - The `pos_aim` outputs equal bits [3:0] of the active player's buttons. They are combinational and gated by state==AIM.
  - Inactive player's buttons are ignored. In every other state these outputs are 0.
- Fire edge: a registered previous-fire bit is kept per player and updated every cycle in all states. An edge is fire=1 with previous=0.
  - Holding fire never retriggers.
  - The inactive player's edges are discarded.
- On an active-player fire edge in AIM:
  - Latch `run`, `rise`, `dir`.
  - Set `shot_x`=`x_pos`, `shot_y`=0, err=0, step counter=0.
  - Next state FLY.
  - If `run`=`rise`=0, use rise=1, run=0 (vertical shot).
- FLY: the step counter counts 0..`STEP_DIV`−1. A step happens on the cycle the count is `STEP_DIV`−1, and the counter then wraps to 0. The 6-bit err accumulator is updated per step:
  - Steep (rise ≥ run): y+=1; err+=run; if err ≥ rise then err−=rise and x moves one column in `dir`.
  - Shallow (rise < run): x moves one column in `dir`; err+=rise; if err ≥ run then err−=run and y+=1.
- End of flight (checked on each step):
  - Wall: if an x move would go below 0 or above 31, do not apply the step (x and y hold) and go to RESULT with miss.
  - Top row: if the new y equals `TOP_Y`, apply the step and go to RESULT with hit = (new x == `target_x`), otherwise miss.
- RESULT lasts exactly 1 cycle:
  - `hit` or `miss` is high during it.
  - On exit: if hit, the active player's score +1, saturating at 15.
  - `turn` toggles, next state AIM.
  - `shot_x`/`shot_y` hold their last values until the next fire.

## Timing
- Fire edge sampled on cycle N: FLY from N+1 and `shot_active`=1. First position update is visible at N+1+`STEP_DIV`.
- Flight of k steps: the RESULT cycle is N+1+k·`STEP_DIV`. `shot_active`=0 in RESULT.
- Score and `turn` update together on the edge after RESULT. AIM with the new player is active from the following cycle.
- `pos_aim` button outputs are combinational from the inputs and state, with zero latency.
- Async reset mid-flight: everything returns to its reset value immediately. No pulse, no score change.

## Test plan
- Vertical shot: turn 0, `x_pos`=10, run=0, rise=5, `target_x`=10, fire pulse. Expect 31 steps, `shot_x`=10 throughout, `hit` pulse, `score0`=1, `turn`=1.
- Wall miss: `x_pos`=28, run=4, rise=1, dir=1. Expect `shot_x` 29, 30, 31, then `miss` with `shot_x`=31, scores unchanged, `turn` toggled.
- Diagonal: `x_pos`=31, run=rise=3, dir=0, `target_x`=0. Expect x and y to change every step, reaching (0, 31), then `hit`.
- Gating: turn=0, drive `p1_btn`=5'b01111. Expect all `pos_aim` outputs 0 and no flight. Then `p0_btn`[2]=1: expect `left_aim`=1 the same cycle.
- Fire held: fire held high across RESULT into the other player's AIM. Expect no new shot. Saturation: 16 hits by player 0 leave `score0`=15.
- Reset mid-flight: assert `reset`=0 at step 5. Expect immediate AIM, `turn`=0, `shot_active`=0, scores 0, no `hit`/`miss`.

Source files
------------

// File: rtl/turn_sequencer.sv
// Two-player turn controller: routes the active player's aim buttons to pos_aim,
// flies a Bresenham projectile on fire, scores the hit or miss and then passes the turn.
module turn_sequencer #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned TOP_Y    = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] p0_btn,
    input  logic [4:0] p1_btn,
    input  logic [4:0] x_pos,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    input  logic [4:0] target_x,
    output logic       left_x,
    output logic       right_x,
    output logic       left_aim,
    output logic       right_aim,
    output logic       turn,
    output logic       shot_active,
    output logic [4:0] shot_x,
    output logic [4:0] shot_y,
    output logic       hit,
    output logic       miss,
    output logic [3:0] score0,
    output logic [3:0] score1
);

    typedef enum logic [1:0] {
        S_AIM    = 2'd0,
        S_FLY    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    state_t           state_q;
    logic             turn_q;
    logic [1:0]       fire_prev_q;
    logic [4:0]       run_q;
    logic [4:0]       rise_q;
    logic             dir_q;
    logic [5:0]       err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       shot_x_q;
    logic [4:0]       shot_y_q;
    logic             hit_q;
    logic             miss_q;
    logic [3:0]       score0_q;
    logic [3:0]       score1_q;

    logic [4:0] act_btn;
    logic       fire_edge;
    logic [5:0] err_acc;
    logic [5:0] err_d;
    logic       x_move;
    logic       y_move;
    logic       wall;
    logic [4:0] shot_x_d;
    logic [5:0] y_sum;
    logic [4:0] shot_y_d;
    logic       at_top;
    logic       step_hit;

    assign act_btn   = turn_q ? p1_btn : p0_btn;
    assign fire_edge = act_btn[4] & ~fire_prev_q[turn_q];

    // Aim buttons pass straight through so pos_aim reacts in the same cycle.
    assign {right_aim, left_aim, right_x, left_x} = (state_q == S_AIM) ? act_btn[3:0] : 4'b0000;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        x_move  = 1'b0;
        y_move  = 1'b0;
        err_acc = 6'd0;
        err_d   = err_q;
        if (rise_q >= run_q) begin
            y_move  = 1'b1;
            err_acc = err_q + {1'b0, run_q};
            if (err_acc >= {1'b0, rise_q}) begin
                err_d  = err_acc - {1'b0, rise_q};
                x_move = 1'b1;
            end else begin
                err_d = err_acc;
            end
        end else begin
            x_move  = 1'b1;
            err_acc = err_q + {1'b0, rise_q};
            if (err_acc >= {1'b0, run_q}) begin
                err_d  = err_acc - {1'b0, run_q};
                y_move = 1'b1;
            end else begin
                err_d = err_acc;
            end
        end
        // A move off either edge of the field ends the flight without moving.
        wall     = x_move & (dir_q ? (shot_x_q == 5'd31) : (shot_x_q == 5'd0));
        shot_x_d = x_move ? (dir_q ? shot_x_q + 5'd1 : shot_x_q - 5'd1) : shot_x_q;
        y_sum    = {1'b0, shot_y_q} + {5'd0, y_move};
        shot_y_d = y_sum[4:0];
        at_top   = (y_sum == 6'(TOP_Y));
        step_hit = (shot_x_d == target_x);
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_AIM;
            turn_q      <= 1'b0;
            fire_prev_q <= 2'b00;
            run_q       <= 5'd0;
            rise_q      <= 5'd0;
            dir_q       <= 1'b0;
            err_q       <= 6'd0;
            cnt_q       <= '0;
            shot_x_q    <= 5'd0;
            shot_y_q    <= 5'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            score0_q    <= 4'd0;
            score1_q    <= 4'd0;
        end else begin
            fire_prev_q <= {p1_btn[4], p0_btn[4]};
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            case (state_q)
                S_AIM: begin
                    if (fire_edge) begin
                        run_q    <= run;
                        rise_q   <= ((run == 5'd0) && (rise == 5'd0)) ? 5'd1 : rise;
                        dir_q    <= dir;
                        shot_x_q <= x_pos;
                        shot_y_q <= 5'd0;
                        err_q    <= 6'd0;
                        cnt_q    <= '0;
                        state_q  <= S_FLY;
                    end
                end
                S_FLY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (wall) begin
                            miss_q  <= 1'b1;
                            state_q <= S_RESULT;
                        end else begin
                            shot_x_q <= shot_x_d;
                            shot_y_q <= shot_y_d;
                            err_q    <= err_d;
                            if (at_top) begin
                                hit_q   <= step_hit;
                                miss_q  <= ~step_hit;
                                state_q <= S_RESULT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (hit_q) begin
                        if (turn_q) begin
                            if (score1_q != 4'hF) score1_q <= score1_q + 4'd1;
                        end else begin
                            if (score0_q != 4'hF) score0_q <= score0_q + 4'd1;
                        end
                    end
                    turn_q  <= ~turn_q;
                    state_q <= S_AIM;
                end
                default: state_q <= S_AIM;
            endcase
        end
    end

    assign turn        = turn_q;
    assign shot_active = (state_q == S_FLY);
    assign shot_x      = shot_x_q;
    assign shot_y      = shot_y_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign score0      = score0_q;
    assign score1      = score1_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: a closed-form trajectory model checked every cycle,
// plus directed shots with hand-computed outcomes.
module tb_turn_sequencer;

    localparam int S    = 4;
    localparam int TOPY = 31;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] p0_btn, p1_btn, x_pos, run, rise, target_x;
    logic       dir;
    logic       left_x, right_x, left_aim, right_aim, turn, shot_active, hit, miss;
    logic [4:0] shot_x, shot_y;
    logic [3:0] score0, score1;

    turn_sequencer #(.STEP_DIV(S), .TOP_Y(TOPY)) dut (
        .clk(clk), .reset(reset), .p0_btn(p0_btn), .p1_btn(p1_btn),
        .x_pos(x_pos), .run(run), .rise(rise), .dir(dir), .target_x(target_x),
        .left_x(left_x), .right_x(right_x), .left_aim(left_aim), .right_aim(right_aim),
        .turn(turn), .shot_active(shot_active), .shot_x(shot_x), .shot_y(shot_y),
        .hit(hit), .miss(miss), .score0(score0), .score1(score1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whole flight planned at fire time from floor(i*run/rise) closed forms.
    typedef enum int {M_AIM, M_FLY, M_RES} mphase_t;
    mphase_t    m_phase = M_AIM;
    int         m_turn = 0, m_s0 = 0, m_s1 = 0, m_x = 0, m_y = 0;
    int         m_age = 0, m_events = 0, m_applied = 0, m_steps = 0;
    int         m_x0 = 0, m_run = 0, m_rise = 0, m_dir = 0;
    bit         m_hit_out = 0;
    bit [1:0]   m_prev = 2'b00;
    logic [4:0] m_act;

    function automatic void pos(input int j, output int px, output int py);
        int d;
        if (m_rise >= m_run) begin
            py = j;
            d  = (j * m_run) / m_rise;
        end else begin
            d  = j;
            py = (j * m_rise) / m_run;
        end
        px = (m_dir != 0) ? m_x0 + d : m_x0 - d;
    endfunction

    task automatic plan_flight();
        int px, py;
        m_x0      = int'(x_pos);
        m_run     = int'(run);
        m_rise    = (run == 0 && rise == 0) ? 1 : int'(rise);
        m_dir     = int'(dir);
        m_applied = 0;
        m_events  = 0;
        m_hit_out = 0;
        for (int i = 1; i <= 2000; i++) begin
            pos(i, px, py);
            if (px < 0 || px > 31) begin
                m_applied = i - 1;
                m_events  = i;
                m_hit_out = 0;
                break;
            end
            if (py == TOPY) begin
                m_applied = i;
                m_events  = i;
                m_hit_out = (px == int'(target_x));
                break;
            end
        end
        m_x     = m_x0;
        m_y     = 0;
        m_age   = 0;
        m_phase = M_FLY;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = M_AIM; m_turn = 0; m_s0 = 0; m_s1 = 0;
            m_x = 0; m_y = 0; m_prev = 2'b00; m_hit_out = 0;
        end else begin
            m_act = (m_turn != 0) ? p1_btn : p0_btn;
            case (m_phase)
                M_AIM: if (m_act[4] && !m_prev[m_turn]) plan_flight();
                M_FLY: begin
                    m_age++;
                    m_steps = m_age / S;
                    if (m_steps > m_applied) m_steps = m_applied;
                    pos(m_steps, m_x, m_y);
                    if (m_age == m_events * S) m_phase = M_RES;
                end
                M_RES: begin
                    if (m_hit_out) begin
                        if (m_turn != 0) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                        else             m_s0 = (m_s0 < 15) ? m_s0 + 1 : 15;
                    end
                    m_turn  = 1 - m_turn;
                    m_phase = M_AIM;
                end
                default: m_phase = M_AIM;
            endcase
            m_prev = {p1_btn[4], p0_btn[4]};
        end
    end

    logic [4:0] c_act;
    logic [3:0] c_btn;
    always @(negedge clk) begin
        c_act = (m_turn != 0) ? p1_btn : p0_btn;
        c_btn = (m_phase == M_AIM) ? c_act[3:0] : 4'b0000;
        check("left_x",      left_x,      c_btn[0]);
        check("right_x",     right_x,     c_btn[1]);
        check("left_aim",    left_aim,    c_btn[2]);
        check("right_aim",   right_aim,   c_btn[3]);
        check("turn",        turn,        m_turn);
        check("shot_active", shot_active, m_phase == M_FLY);
        check("shot_x",      shot_x,      m_x);
        check("shot_y",      shot_y,      m_y);
        check("hit",         hit,         (m_phase == M_RES) && m_hit_out);
        check("miss",        miss,        (m_phase == M_RES) && !m_hit_out);
        check("score0",      score0,      m_s0);
        check("score1",      score1,      m_s1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic shoot(input int who, input int x, input int r, input int ri, input int d,
                         input int tgt, input bit hold, output int cycles, output bit got_hit);
        x_pos = 5'(x); run = 5'(r); rise = 5'(ri); dir = d[0]; target_x = 5'(tgt);
        if (who == 0) p0_btn[4] = 1'b1; else p1_btn[4] = 1'b1;
        tick(1);
        check("active_after_fire", shot_active, 1);
        if (!hold) begin
            if (who == 0) p0_btn[4] = 1'b0; else p1_btn[4] = 1'b0;
        end
        cycles = 0;
        while (!(hit || miss) && cycles < 3000) begin
            tick(1);
            cycles++;
        end
        check("flight_ends", hit | miss, 1);
        got_hit = hit;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int cyc;
    bit h;

    initial begin
        reset = 1'b0;
        p0_btn = '0; p1_btn = '0; x_pos = '0; run = '0; rise = '0; dir = 1'b0; target_x = '0;
        tick(3);
        check("rst_turn", turn, 0);
        check("rst_score0", score0, 0);
        check("rst_shot_x", shot_x, 0);
        check("rst_active", shot_active, 0);
        reset = 1'b1;
        tick(2);

        // Inactive player's buttons and fire are ignored.
        p1_btn = 5'b01111;
        #1;
        check("gate_left_x", left_x, 0);
        check("gate_right_x", right_x, 0);
        check("gate_left_aim", left_aim, 0);
        check("gate_right_aim", right_aim, 0);
        tick(3);
        p1_btn = 5'b11111;
        tick(2);
        check("gate_no_flight", shot_active, 0);
        p1_btn = 5'b00000;
        p0_btn = 5'b00100;
        #1;
        check("left_aim_same_cycle", left_aim, 1);
        check("right_aim_quiet", right_aim, 0);
        tick(1);
        p0_btn = 5'b00000;
        tick(1);

        // Vertical shot: 31 steps of 4 cycles, straight up into the target.
        shoot(0, 10, 0, 5, 1, 10, 1'b0, cyc, h);
        check("vert_cycles", 8'(cyc), 124);
        check("vert_hit", h, 1);
        check("vert_score0", score0, 1);
        check("vert_turn", turn, 1);
        check("vert_x", shot_x, 10);
        check("vert_y", shot_y, 31);

        // Wall miss: x 29, 30, 31 then the 4th step would leave the field.
        shoot(1, 28, 4, 1, 1, 5, 1'b0, cyc, h);
        check("wall_cycles", 8'(cyc), 16);
        check("wall_hit", h, 0);
        check("wall_x", shot_x, 31);
        check("wall_y", shot_y, 0);
        check("wall_score1", score1, 0);
        check("wall_turn", turn, 0);

        // Diagonal from the right edge to (0,31).
        shoot(0, 31, 3, 3, 0, 0, 1'b0, cyc, h);
        check("diag_cycles", 8'(cyc), 124);
        check("diag_hit", h, 1);
        check("diag_x", shot_x, 0);
        check("diag_y", shot_y, 31);
        check("diag_score0", score0, 2);

        // Both fire buttons held through the RESULT cycle: no new shot.
        p0_btn[4] = 1'b1;
        tick(1);
        shoot(1, 5, 0, 1, 0, 20, 1'b1, cyc, h);
        check("held_miss", h, 0);
        check("held_turn", turn, 0);
        tick(10);
        check("held_no_shot", shot_active, 0);
        p0_btn[4] = 1'b0;
        p1_btn[4] = 1'b0;
        tick(2);

        // Saturation: 16 more hits by player 0, player 1 misses at the wall.
        for (int i = 0; i < 16; i++) begin
            shoot(0, 3, 0, 1, 1, 3, 1'b0, cyc, h);
            if (i == 12) check("sat_reach15", score0, 15);
            shoot(1, 31, 1, 0, 1, 0, 1'b0, cyc, h);
        end
        check("sat_score0", score0, 15);
        check("sat_score1", score1, 0);

        // Asynchronous reset during the fifth step of a flight.
        x_pos = 5'd7; run = 5'd0; rise = 5'd1; dir = 1'b1; target_x = 5'd7;
        p0_btn[4] = 1'b1;
        tick(1);
        p0_btn[4] = 1'b0;
        tick(5 * S);
        #1;
        check("pre_reset_active", shot_active, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_active", shot_active, 0);
        check("mid_rst_turn", turn, 0);
        check("mid_rst_score0", score0, 0);
        check("mid_rst_shot_y", shot_y, 0);
        check("mid_rst_hit", hit, 0);
        check("mid_rst_miss", miss, 0);
        tick(3);
        reset = 1'b1;
        tick(20);
        check("post_rst_idle", shot_active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
